// File: rtl/hex_to_8seg_if.sv
// hex_to_8seg_if: display data bundle between the data path and the segment encoder
interface hex_to_8seg_if;
  logic [31:0] Hexs;
  logic [7:0]  points;
  logic [7:0]  LES;
  logic        flash;
  logic [63:0] SEG_TXT;
  modport master (output Hexs, points, LES, flash, input SEG_TXT);
  modport slave  (input Hexs, points, LES, flash, output SEG_TXT);
endinterface

// File: rtl/hex_to_8seg.sv
// hex_to_8seg: 32-bit value to eight registered 7-segment bytes with dp and blink; SEG_ACTIVE_HIGH_EN inverts polarity
module hex_to_8seg (
  input logic clk,
  input logic rst,
  hex_to_8seg_if.slave bus
);
`ifdef SEG_ACTIVE_HIGH_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif
  localparam logic [7:0] BLANK = 8'hFF ^ INV;
  localparam logic [7:0] LUT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic [63:0] w_seg;
  logic [63:0] r_seg;
  // blanking wins over the decimal point, so it is applied last
  for (genvar g = 0; g < 8; g++) begin : g_dig
    assign w_seg[8*g +: 8] = ((bus.LES[g] && bus.flash) ? 8'hFF
                            : {~bus.points[g], LUT[bus.Hexs[4*g +: 4]][6:0]}) ^ INV;
  end
  // register the encoded digits; reset shows all digits blank
  always_ff @(posedge clk)
    r_seg <= rst ? {8{BLANK}} : w_seg;
  assign bus.SEG_TXT = r_seg;
endmodule

// File: tb/tb_hex_to_8seg.sv
// tb_hex_to_8seg: scoreboard bench with directed vectors for hex_to_8seg
module tb_hex_to_8seg;
`ifdef SEG_ACTIVE_HIGH_EN
  localparam logic [63:0] INV64 = {64{1'b1}};
`else
  localparam logic [63:0] INV64 = '0;
`endif
  typedef struct {
    logic        rst;
    logic [31:0] hexs;
    logic [7:0]  pts;
    logic [7:0]  les;
    logic        fl;
    logic [63:0] exp;
    string       name;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];
  string nm_q[$];
  bit done = 0;
  hex_to_8seg_if bus ();
  hex_to_8seg dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  vec_t v[$];
  initial begin
    v.push_back('{1, 32'h12345678, 8'h00, 8'h00, 0, 64'hFFFFFFFFFFFFFFFF, "reset"});
    v.push_back('{0, 32'h12345678, 8'h00, 8'h00, 0, 64'hF9A4B0999282F880, "first"});
    v.push_back('{0, 32'hA5A5A5A5, 8'h00, 8'h00, 0, 64'h8892889288928892, "a5"});
    v.push_back('{0, 32'h12345678, 8'h00, 8'h00, 0, 64'hF9A4B0999282F880, "back"});
    v.push_back('{0, 32'h01234567, 8'h00, 8'h00, 0, 64'hC0F9A4B0999282F8, "tbl_lo"});
    v.push_back('{0, 32'h89ABCDEF, 8'h00, 8'h00, 0, 64'h80908883C6A1868E, "tbl_hi"});
    v.push_back('{0, 32'h12345678, 8'h81, 8'h00, 0, 64'h79A4B0999282F800, "points"});
    v.push_back('{0, 32'h12345678, 8'h01, 8'h0F, 1, 64'hF9A4B099FFFFFFFF, "blink_on"});
    v.push_back('{0, 32'h12345678, 8'h01, 8'h0F, 0, 64'hF9A4B0999282F800, "blink_off"});
    v.push_back('{0, 32'h12345678, 8'h00, 8'h00, 1, 64'hF9A4B0999282F880, "les_zero"});
    v.push_back('{0, 32'hFEDCBA98, 8'hFF, 8'hF0, 1, 64'hFFFFFFFF03081000, "mix"});
    v.push_back('{0, 32'h00000000, 8'h00, 8'h00, 0, 64'hC0C0C0C0C0C0C0C0, "zeros"});
    v.push_back('{0, 32'h11111111, 8'h00, 8'h00, 0, 64'hF9F9F9F9F9F9F9F9, "ones"});
    v.push_back('{1, 32'h22222222, 8'h00, 8'h00, 0, 64'hFFFFFFFFFFFFFFFF, "mid_rst"});
    v.push_back('{0, 32'h33333333, 8'h00, 8'h00, 0, 64'hB0B0B0B0B0B0B0B0, "post_rst"});
    foreach (v[k]) begin
      @(negedge clk);
      rst = v[k].rst;
      bus.Hexs = v[k].hexs;
      bus.points = v[k].pts;
      bus.LES = v[k].les;
      bus.flash = v[k].fl;
      sb_q.push_back(v[k].exp ^ INV64);
      nm_q.push_back(v[k].name);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  always begin
    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      logic [63:0] e;
      string n;
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      tests++;
      if (bus.SEG_TXT !== e) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", n, bus.SEG_TXT, e);
      end
    end
  end
  initial begin
    #5000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
    end
  end
endmodule
